// File: rtl/perm_cmd_scheduler_if.sv
// perm_cmd_scheduler_if: requester, permutation-unit and status bundle.
// master = scheduler side, slave = requesters/unit side.
interface perm_cmd_scheduler_if #(
  parameter int NumReq         = 2,
  parameter int DataWidth      = 16,
  parameter int MaxOutstanding = 4
);
  localparam int SHW = $clog2(DataWidth);
  localparam int IDW = $clog2(NumReq);
  localparam int OW  = $clog2(MaxOutstanding) + 1;

  logic [NumReq-1:0]           req_valid;
  logic [NumReq-1:0]           req_ready;
  logic [NumReq*3-1:0]         req_mode;
  logic [NumReq*DataWidth-1:0] req_mask;
  logic [NumReq*SHW-1:0]       req_rshift;
  logic                        perm_inValid;
  logic                        perm_inReady;
  logic                        perm_permute;
  logic [2:0]                  perm_mode;
  logic [DataWidth-1:0]        perm_mask_idx_bit;
  logic [SHW-1:0]              perm_rshift_idx_bit;
  logic [IDW-1:0]              perm_data_sel;
  logic                        perm_outValid;
  logic                        perm_outReady;
  logic [NumReq-1:0]           rsp_valid;
  logic [NumReq-1:0]           rsp_ready;
  logic                        busy;
  logic [OW-1:0]               outstanding;
  logic [31:0]                 perf_issued;
  logic [31:0]                 perf_stall;

  modport master (
    input  req_valid, req_mode, req_mask, req_rshift,
    input  perm_inReady, perm_outValid, rsp_ready,
    output req_ready, perm_inValid, perm_permute,
    output perm_mode, perm_mask_idx_bit,
    output perm_rshift_idx_bit, perm_data_sel,
    output perm_outReady, rsp_valid, busy,
    output outstanding, perf_issued, perf_stall
  );

  modport slave (
    output req_valid, req_mode, req_mask, req_rshift,
    output perm_inReady, perm_outValid, rsp_ready,
    input  req_ready, perm_inValid, perm_permute,
    input  perm_mode, perm_mask_idx_bit,
    input  perm_rshift_idx_bit, perm_data_sel,
    input  perm_outReady, rsp_valid, busy,
    input  outstanding, perf_issued, perf_stall
  );
endinterface

// File: rtl/perm_cmd_scheduler.sv
// perm_cmd_scheduler: round-robin command issue + ID FIFO result routing.
// Ports: clock, reset (async low), io_bus (master). Macro: PERM_SCHED_PERF_EN.
module perm_cmd_scheduler #(
  parameter int NumReq         = 2,
  parameter int DataWidth      = 16,
  parameter int MaxOutstanding = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  perm_cmd_scheduler_if.master  io_bus
);
  localparam int SHW = $clog2(DataWidth);
  localparam int IDW = $clog2(NumReq);
  localparam int OW  = $clog2(MaxOutstanding) + 1;
  localparam int PW  = (MaxOutstanding > 1) ?
                       $clog2(MaxOutstanding) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t               r_state, w_next;
  logic [IDW-1:0]       r_rr, r_sel, w_win, w_head;
  logic [2:0]           r_mode, r_last_mode, w_win_mode;
  logic [DataWidth-1:0] r_mask;
  logic [SHW-1:0]       r_rshift;
  logic [IDW-1:0]       r_fifo [MaxOutstanding];
  logic [PW-1:0]        r_wr, r_rd;
  logic [OW-1:0]        r_cnt;
  logic                 w_found, w_full, w_empty;
  logic                 w_push, w_pop, w_go;

  assign w_full  = (r_cnt == OW'(MaxOutstanding));
  assign w_empty = (r_cnt == '0);
  assign w_head  = r_fifo[r_rd];
  assign w_push  = (r_state == ISSUE) && io_bus.perm_inReady;
  assign w_pop   = io_bus.perm_outValid && io_bus.perm_outReady;

  // Descending scan so the lowest offset from r_rr wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (io_bus.req_valid[(int'(r_rr) + i) % NumReq]) begin
        w_found = 1'b1;
        w_win   = IDW'((int'(r_rr) + i) % NumReq);
      end
    end
  end

  assign w_win_mode = io_bus.req_mode[3*int'(w_win) +: 3];
  assign w_go = (r_state == IDLE) && w_found && !w_full;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:
        if (w_go)
          w_next = (!w_empty && w_win_mode != r_last_mode) ?
                   DRAIN : ISSUE;
      DRAIN:
        if (w_empty) w_next = ISSUE;
      ISSUE:
        if (io_bus.perm_inReady) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mode      <= '0;
      r_mask      <= '0;
      r_rshift    <= '0;
      r_sel       <= '0;
      r_last_mode <= '0;
      r_rr        <= '0;
    end else begin
      if (w_go) begin
        r_mode   <= w_win_mode;
        r_mask   <= io_bus.req_mask[int'(w_win)*DataWidth +: DataWidth];
        r_rshift <= io_bus.req_rshift[int'(w_win)*SHW +: SHW];
        r_sel    <= w_win;
      end
      if (w_push) begin
        r_last_mode <= r_mode;
        r_rr <= (r_sel == IDW'(NumReq - 1)) ? '0 : r_sel + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MaxOutstanding; i++) r_fifo[i] <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr] <= r_sel;
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end

  always_comb begin
    io_bus.req_ready = '0;
    if (w_push) io_bus.req_ready[r_sel] = 1'b1;
  end

  always_comb begin
    io_bus.rsp_valid = '0;
    if (io_bus.perm_outValid && !w_empty)
      io_bus.rsp_valid[w_head] = 1'b1;
  end

  assign io_bus.perm_outReady = !w_empty && io_bus.rsp_ready[w_head];
  assign io_bus.perm_inValid  = (r_state == ISSUE);
  assign io_bus.perm_permute  = (r_state == ISSUE) && (r_mode != 3'd0);
  assign io_bus.perm_mode           = r_mode;
  assign io_bus.perm_mask_idx_bit   = r_mask;
  assign io_bus.perm_rshift_idx_bit = r_rshift;
  assign io_bus.perm_data_sel       = r_sel;
  assign io_bus.busy        = !w_empty || (r_state != IDLE);
  assign io_bus.outstanding = r_cnt;

`ifdef PERM_SCHED_PERF_EN
  logic [31:0] r_perf_issued, r_perf_stall;
  logic        w_stall;

  assign w_stall = (r_state == DRAIN) ||
                   ((r_state == IDLE) && (|io_bus.req_valid) && w_full);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_perf_issued <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_push && r_perf_issued != '1)
        r_perf_issued <= r_perf_issued + 1'b1;
      if (w_stall && r_perf_stall != '1)
        r_perf_stall <= r_perf_stall + 1'b1;
    end
  end

  assign io_bus.perf_issued = r_perf_issued;
  assign io_bus.perf_stall  = r_perf_stall;
`else
  assign io_bus.perf_issued = '0;
  assign io_bus.perf_stall  = '0;
`endif
endmodule

// File: tb/tb_perm_cmd_scheduler.sv
// tb_perm_cmd_scheduler: directed bench for perm_cmd_scheduler.
// Drives the slave side of the bundle at negedge, checks 1 time unit later.
module tb_perm_cmd_scheduler;
  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  perm_cmd_scheduler_if #(
    .NumReq(2), .DataWidth(16), .MaxOutstanding(4)
  ) bus ();

  perm_cmd_scheduler #(
    .NumReq(2), .DataWidth(16), .MaxOutstanding(4)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] m,
                         input logic [15:0] k,
                         input logic [3:0] s);
    bus.req_mode[3*i +: 3]    = m;
    bus.req_mask[16*i +: 16]  = k;
    bus.req_rshift[4*i +: 4]  = s;
  endtask

  // Advance at least one cycle, then poll for the expected ready pattern.
  task automatic wait_rdy(input logic [1:0] exp, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (bus.req_ready !== exp && n < 20);
    chk(tag, 32'(bus.req_ready), 32'(exp));
  endtask

  initial begin
    int issued, c0, c1, cyc;
    logic [1:0] exp_g;
    clk = 0;
    rst_n = 0;
    bus.req_valid = '0;
    bus.req_mode = '0;
    bus.req_mask = '0;
    bus.req_rshift = '0;
    bus.perm_inReady = 1'b1;
    bus.perm_outValid = 1'b0;
    bus.rsp_ready = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_inValid", 32'(bus.perm_inValid), 0);
    chk("rst_outstanding", 32'(bus.outstanding), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_mode", 32'(bus.perm_mode), 0);
    chk("rst_sel", 32'(bus.perm_data_sel), 0);
    chk("rst_outReady", 32'(bus.perm_outReady), 0);
    chk("rst_perf_issued", bus.perf_issued, 0);
    chk("rst_perf_stall", bus.perf_stall, 0);
    @(negedge clk);
    rst_n = 1;

    // Single command from requester 0.
    @(negedge clk);
    set_req(0, 3'd3, 16'h00F0, 4'd4);
    bus.req_valid = 2'b01;
    #1;
    chk("t1_pre_inValid", 32'(bus.perm_inValid), 0);
    chk("t1_pre_ready", 32'(bus.req_ready), 0);
    @(negedge clk); #1;
    chk("t1_inValid", 32'(bus.perm_inValid), 1);
    chk("t1_mode", 32'(bus.perm_mode), 3);
    chk("t1_mask", 32'(bus.perm_mask_idx_bit), 32'h00F0);
    chk("t1_rshift", 32'(bus.perm_rshift_idx_bit), 4);
    chk("t1_permute", 32'(bus.perm_permute), 1);
    chk("t1_sel", 32'(bus.perm_data_sel), 0);
    chk("t1_ready", 32'(bus.req_ready), 32'b01);
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    chk("t1_out1", 32'(bus.outstanding), 1);
    chk("t1_inValid_lo", 32'(bus.perm_inValid), 0);
    chk("t1_busy", 32'(bus.busy), 1);
`ifdef PERM_SCHED_PERF_EN
    chk("t1_perf_issued", bus.perf_issued, 1);
`endif
    @(negedge clk);
    bus.perm_outValid = 1'b1;
    bus.rsp_ready = 2'b01;
    #1;
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'b01);
    chk("t1_outReady", 32'(bus.perm_outReady), 1);
    @(negedge clk);
    bus.perm_outValid = 1'b0;
    bus.rsp_ready = 2'b00;
    #1;
    chk("t1_out0", 32'(bus.outstanding), 0);
    chk("t1_idle", 32'(bus.busy), 0);

    // Reset so round-robin restarts at requester 0.
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;

    // Both requesters valid, same mode, results retired at once.
    @(negedge clk);
    set_req(0, 3'd1, 16'h1111, 4'd1);
    set_req(1, 3'd1, 16'h2222, 4'd2);
    bus.req_valid = 2'b11;
    bus.perm_outValid = 1'b1;
    bus.rsp_ready = 2'b11;
    #1;
    chk("t2_empty_outReady", 32'(bus.perm_outReady), 0);
    chk("t2_empty_rsp", 32'(bus.rsp_valid), 0);
    issued = 0; c0 = 0; c1 = 0; cyc = 0;
    exp_g = 2'b01;
    while (issued < 8 && cyc < 40) begin
      @(negedge clk); #1;
      cyc++;
      if (bus.req_ready != 2'b00) begin
        chk("t2_grant", 32'(bus.req_ready), 32'(exp_g));
        if (bus.req_ready[0]) c0++;
        if (bus.req_ready[1]) c1++;
        exp_g = ~exp_g;
        issued++;
      end
    end
    chk("t2_issued", 32'(issued), 8);
    chk("t2_cnt0", 32'(c0), 4);
    chk("t2_cnt1", 32'(c1), 4);
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    bus.perm_outValid = 1'b0;
    bus.rsp_ready = 2'b00;
    #1;
    chk("t2_out0", 32'(bus.outstanding), 0);

    // Unit stalls input for 5 cycles.
    @(negedge clk);
    bus.perm_inReady = 1'b0;
    set_req(1, 3'd2, 16'hA5A5, 4'd7);
    bus.req_valid = 2'b10;
    #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) set_req(1, 3'd2, 16'hFFFF, 4'd3);
      #1;
      chk("t3_inValid", 32'(bus.perm_inValid), 1);
      chk("t3_sel", 32'(bus.perm_data_sel), 1);
      chk("t3_mask", 32'(bus.perm_mask_idx_bit), 32'hA5A5);
      chk("t3_rshift", 32'(bus.perm_rshift_idx_bit), 7);
      chk("t3_ready_lo", 32'(bus.req_ready), 0);
    end
    @(negedge clk);
    bus.perm_inReady = 1'b1;
    #1;
    chk("t3_ready", 32'(bus.req_ready), 32'b10);
    chk("t3_mode", 32'(bus.perm_mode), 2);
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    chk("t3_out1", 32'(bus.outstanding), 1);
    @(negedge clk);
    bus.perm_outValid = 1'b1;
    bus.rsp_ready = 2'b01;
    #1;
    chk("t3_rsp_valid", 32'(bus.rsp_valid), 32'b10);
    chk("t3_wrong_rdy", 32'(bus.perm_outReady), 0);
    @(negedge clk);
    bus.rsp_ready = 2'b10;
    #1;
    chk("t3_outReady", 32'(bus.perm_outReady), 1);
    @(negedge clk);
    bus.perm_outValid = 1'b0;
    bus.rsp_ready = 2'b00;
    #1;
    chk("t3_out0", 32'(bus.outstanding), 0);

    // Two mode-1 ops, then a mode-2 request must drain first.
    @(negedge clk);
    set_req(0, 3'd1, 16'h0F0F, 4'd2);
    bus.req_valid = 2'b01;
    #1;
    wait_rdy(2'b01, "t4_issue1");
    wait_rdy(2'b01, "t4_issue2");
    @(negedge clk);
    set_req(0, 3'd2, 16'h0F0F, 4'd2);
    #1;
    chk("t4_out2", 32'(bus.outstanding), 2);
    @(negedge clk); #1;
    chk("t4_drain_inValid", 32'(bus.perm_inValid), 0);
    chk("t4_drain_ready", 32'(bus.req_ready), 0);
    chk("t4_drain_busy", 32'(bus.busy), 1);
    @(negedge clk); #1;
    chk("t4_drain_inValid2", 32'(bus.perm_inValid), 0);
    @(negedge clk);
    bus.perm_outValid = 1'b1;
    bus.rsp_ready = 2'b01;
    #1;
    chk("t4_rsp_valid", 32'(bus.rsp_valid), 32'b01);
    @(negedge clk); #1;
    chk("t4_drain_inValid3", 32'(bus.perm_inValid), 0);
    chk("t4_out1", 32'(bus.outstanding), 1);
    @(negedge clk);
    bus.perm_outValid = 1'b0;
    bus.rsp_ready = 2'b00;
    #1;
    chk("t4_drain_inValid4", 32'(bus.perm_inValid), 0);
    chk("t4_out0", 32'(bus.outstanding), 0);
    @(negedge clk); #1;
    chk("t4_inValid", 32'(bus.perm_inValid), 1);
    chk("t4_mode", 32'(bus.perm_mode), 2);
    chk("t4_ready", 32'(bus.req_ready), 32'b01);

    // Fill to MaxOutstanding, then retire one to let the fifth go.
    wait_rdy(2'b01, "t5_issue2");
    wait_rdy(2'b01, "t5_issue3");
    wait_rdy(2'b01, "t5_issue4");
    @(negedge clk); #1;
    chk("t5_full", 32'(bus.outstanding), 4);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("t5_full_ready", 32'(bus.req_ready), 0);
      chk("t5_full_inValid", 32'(bus.perm_inValid), 0);
    end
    @(negedge clk);
    bus.perm_outValid = 1'b1;
    bus.rsp_ready = 2'b01;
    #1;
    chk("t5_retire_rdy", 32'(bus.perm_outReady), 1);
    @(negedge clk);
    bus.perm_outValid = 1'b0;
    #1;
    chk("t5_out3", 32'(bus.outstanding), 3);
    chk("t5_not_yet", 32'(bus.perm_inValid), 0);
    @(negedge clk);
    bus.perm_outValid = 1'b1;
    #1;
    chk("t5_fifth_inValid", 32'(bus.perm_inValid), 1);
    chk("t5_fifth_ready", 32'(bus.req_ready), 32'b01);
    chk("t5_both_outReady", 32'(bus.perm_outReady), 1);
    @(negedge clk);
    bus.perm_outValid = 1'b0;
    bus.rsp_ready = 2'b00;
    bus.req_valid = 2'b00;
    #1;
    chk("t5_same_cycle", 32'(bus.outstanding), 3);

    // Reset while in ISSUE with three ops in flight.
    @(negedge clk);
    bus.perm_inReady = 1'b0;
    set_req(1, 3'd2, 16'h1234, 4'd5);
    bus.req_valid = 2'b10;
    #1;
    @(negedge clk); #1;
    chk("t6_issue", 32'(bus.perm_inValid), 1);
    chk("t6_sel1", 32'(bus.perm_data_sel), 1);
    #2;
    bus.perm_outValid = 1'b1;
    rst_n = 0;
    #1;
    chk("t6_inValid", 32'(bus.perm_inValid), 0);
    chk("t6_outstanding", 32'(bus.outstanding), 0);
    chk("t6_busy", 32'(bus.busy), 0);
    chk("t6_mode", 32'(bus.perm_mode), 0);
    chk("t6_mask", 32'(bus.perm_mask_idx_bit), 0);
    chk("t6_sel", 32'(bus.perm_data_sel), 0);
    chk("t6_permute", 32'(bus.perm_permute), 0);
    chk("t6_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("t6_outReady", 32'(bus.perm_outReady), 0);
    @(negedge clk);
    rst_n = 1;
    bus.perm_outValid = 1'b0;
    bus.perm_inReady = 1'b1;
    set_req(0, 3'd2, 16'h4321, 4'd1);
    bus.req_valid = 2'b11;
    #1;
    @(negedge clk); #1;
    chk("t6_first_sel", 32'(bus.perm_data_sel), 0);
    chk("t6_first_ready", 32'(bus.req_ready), 32'b01);
    @(negedge clk);
    bus.req_valid = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/perm_cmd_scheduler.md
Name: perm_cmd_scheduler

Overview:
- Control-side scheduler for the SIMD permutation unit; the unit's data bus does not pass through this block.
- Accepts permutation commands (mode, mask index bits, right-shift index bits) from NumReq requesters and round-robin arbitrates between them.
- Drives the unit's input handshake and configuration signals, plus a data-select index for the external operand mux.
- Tracks in-flight operations in an ID FIFO and routes each result handshake back to the requester that issued it. Stalls on configuration hazards.

Parameters:
NumReq, 2, number of requesters (>=2)
DataWidth, 16, width of mask index field
MaxOutstanding, 4, max ops in flight inside the permutation unit (power of 2)
SHW, $clog2(DataWidth), width of right-shift index field
IDW, $clog2(NumReq), requester ID width

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  NumReq  per-requester command valid
req_ready  out  NumReq  per-requester command accepted
req_mode  in  NumReq*3  per-requester mode, requester i at [3i+:3]
req_mask  in  NumReq*DataWidth  per-requester mask_idx_bit
req_rshift  in  NumReq*SHW  per-requester rshift_idx_bit
perm_inValid  out  1  to unit io_inValid
perm_inReady  in  1  from unit io_inReady
perm_permute  out  1  to unit io_permute
perm_mode  out  3  to unit io_mode
perm_mask_idx_bit  out  DataWidth  to unit io_mask_idx_bit
perm_rshift_idx_bit  out  SHW  to unit io_rshift_idx_bit
perm_data_sel  out  IDW  operand-mux select (granted requester)
perm_outValid  in  1  from unit io_outValid
perm_outReady  out  1  to unit io_outReady
rsp_valid  out  NumReq  result valid to owning requester
rsp_ready  in  NumReq  result consumed by requester
busy  out  1  outstanding != 0 or state != IDLE
outstanding  out  $clog2(MaxOutstanding)+1  ops in flight

Behaviour:
- Reset (reset=0, async): state=IDLE; rr pointer=0; outstanding=0; ID FIFO empty. All outputs 0.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - If any req_valid and outstanding<MaxOutstanding, pick a winner round-robin, starting at the rr pointer.
  - Register the winner's mode, mask and rshift into the perm_* config outputs, and the winner's index into perm_data_sel.
  - If outstanding!=0 and the winner's mode differs from last_mode, go to DRAIN. Otherwise go to ISSUE.
- DRAIN: stay until outstanding==0, then go to ISSUE. Config outputs and grant are frozen.
- ISSUE:
  - perm_inValid=1. Config, perm_data_sel and grant stay stable until perm_inReady=1.
  - On the handshake:
    - req_ready[grant]=1 for that cycle only.
    - Push grant into the ID FIFO; outstanding+1; last_mode<=perm_mode.
    - rr pointer <= grant+1, wrapping at NumReq.
    - Go to IDLE.
- Latency: req_valid in cycle t with the unit ready gives perm_inValid at t+1 and req_ready at t+1. Max issue rate is one command per 2 cycles.
- perm_permute = (perm_mode != 0); mode 0 is bypass. Forced to 0 when perm_inValid=0.
- Response routing:
  - head = ID FIFO head.
  - rsp_valid[head] = perm_outValid && !empty; all other rsp_valid are 0.
  - perm_outReady = !empty && rsp_ready[head].
  - On perm_outValid && perm_outReady: pop the FIFO; outstanding-1.
- Same-cycle issue and retire: outstanding unchanged; FIFO push and pop both take effect.
- outstanding==MaxOutstanding: IDLE does not arbitrate and req_ready stays 0.
- perm_outValid with an empty FIFO is a protocol error: perm_outReady=0 and state is unchanged.
- A requester dropping req_valid while granted in ISSUE is illegal. The grant is held regardless.
- Mid-operation reset clears all state immediately, including in-flight IDs. The unit itself must also be reset.

Optional Feature:
PERM_SCHED_PERF_EN
- Defined: adds outputs perf_issued (32b) and perf_stall (32b).
  - perf_issued counts input handshakes.
  - perf_stall counts cycles in DRAIN plus IDLE cycles with req_valid!=0 and outstanding full.
  - Both saturate at 2^32-1 and clear on reset.
- Undefined: the ports are still present, tied to 0, with no counter logic.

Test Plan:
- Single cmd, req 0, mode=3, mask=0x00F0, rshift=4, unit always ready: inValid at t+1 with those config values, perm_permute=1, data_sel=0, req_ready[0] at t+1. Result returns on rsp_valid[0]; outstanding goes 0->1->0.
- Both requesters continuously valid, same mode: grants alternate 0,1,0,1. After 8 issues each requester has exactly 4 req_ready pulses.
- Unit holds inReady=0 for 5 cycles: perm_inValid stays 1 with config and data_sel unchanged; req_ready stays 0 until the handshake.
- Issue 2 ops in mode 1, then a request in mode 2: FSM enters DRAIN and perm_inValid=0 until both results retire, then issues mode 2.
- With MaxOutstanding=4: 4 issues with outValid held 0 gives outstanding=4 and a fifth request is not accepted. After one result retires (rsp_ready=1), the fifth issues. Check same-cycle issue+retire keeps the count constant.
- Assert reset low mid-ISSUE with outstanding=3: all outputs 0 and outstanding=0 immediately. After release, the first grant goes to requester 0.
